// File: rtl/tensor_core_host_sequencer.sv
// rtl/tensor_core_host_sequencer.sv - host command sequencer for the tensor core controller
// Serialises write/operate/read/reset commands into the DDR instruction stream and collects burst-read results.
module tensor_core_host_sequencer #(
  parameter int          OPERATE_WAIT_CYCLES = 6,
  parameter logic [15:0] IDLE_INSTRUCTION    = 16'h0000
) (
  input  logic         clock_in,
  input  logic         reset_in,
  input  logic         cmd_valid_in,
  output logic         cmd_ready_out,
  input  logic [1:0]   cmd_op_in,
  input  logic [2:0]   cmd_opselect_in,
  input  logic [143:0] write_matrices_in,
  output logic [15:0]  instruction_out,
  input  logic [7:0]   controller_data_in,
  output logic [71:0]  read_data_out,
  output logic         read_valid_out,
  output logic         busy_out
);

  typedef enum logic [3:0] {
    IDLE, W_HDR, W_DATA, OP_ISSUE, OP_WAIT, R_HDR, R_DATA, RST, R_DONE
  } state_t;

  state_t          state;
  logic [159:0]    mat_q;
  logic [2:0]      grp;
  logic [7:0]      wait_cnt;
  logic [15:0]     instr_q;
  logic [15:0]     lo_q;
  logic            pos_q;
  logic            neg_q;
  logic [4:0][7:0] shadow_even;
  logic [3:0][7:0] shadow_odd;
  logic [4:0]      next_k;

  // Bytes 18/19 live in the zero pad above the snapshot, so group 4 needs no special case.
  function automatic logic [15:0] word_at(input logic [159:0] m, input logic [4:0] k);
    logic [7:0] b;
    b = {k, 3'b000};
    return {m[b +: 8], m[b + 8'd8 +: 8]};
  endfunction

  assign next_k          = {grp + 3'd1, 2'b00};
  assign cmd_ready_out   = (state == IDLE);
  assign busy_out        = ~cmd_ready_out;
  // Low phase is flagged when the negedge flag has diverged from the posedge flag.
  assign instruction_out = (pos_q ^ neg_q) ? lo_q : instr_q;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state          <= IDLE;
      mat_q          <= '0;
      grp            <= '0;
      wait_cnt       <= '0;
      instr_q        <= IDLE_INSTRUCTION;
      lo_q           <= IDLE_INSTRUCTION;
      pos_q          <= 1'b0;
      shadow_odd     <= '0;
      read_data_out  <= '0;
      read_valid_out <= 1'b0;
    end else begin
      pos_q          <= neg_q;
      read_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          instr_q <= IDLE_INSTRUCTION;
          if (cmd_valid_in) begin
            mat_q <= {16'h0000, write_matrices_in};
            case (cmd_op_in)
              2'd0: begin state <= W_HDR;    instr_q <= 16'h0007; end
              2'd1: begin state <= OP_ISSUE; instr_q <= {11'b0, cmd_opselect_in, 2'b10}; end
              2'd2: begin state <= R_HDR;    instr_q <= 16'h0003; end
              default: begin state <= RST;   instr_q <= 16'h000C; end
            endcase
          end
        end
        W_HDR: begin
          state   <= W_DATA;
          grp     <= 3'd0;
          instr_q <= word_at(mat_q, 5'd0);
          lo_q    <= word_at(mat_q, 5'd2);
        end
        W_DATA: begin
          if (grp == 3'd4) begin
            state   <= IDLE;
            instr_q <= IDLE_INSTRUCTION;
            lo_q    <= IDLE_INSTRUCTION;
          end else begin
            grp     <= grp + 3'd1;
            instr_q <= word_at(mat_q, next_k);
            lo_q    <= word_at(mat_q, next_k + 5'd2);
          end
        end
        OP_ISSUE: begin
          state    <= OP_WAIT;
          instr_q  <= IDLE_INSTRUCTION;
          wait_cnt <= '0;
        end
        OP_WAIT: begin
          instr_q <= IDLE_INSTRUCTION;
          if (wait_cnt == 8'(OPERATE_WAIT_CYCLES - 1)) state <= IDLE;
          else wait_cnt <= wait_cnt + 8'd1;
        end
        R_HDR: begin
          state   <= R_DATA;
          grp     <= 3'd0;
          instr_q <= IDLE_INSTRUCTION;
        end
        R_DATA: begin
          // Group 4's low-phase byte is the controller wrapping to element 0; drop it.
          if (grp != 3'd4) shadow_odd[grp[1:0]] <= controller_data_in;
          if (grp == 3'd4) state <= R_DONE;
          else grp <= grp + 3'd1;
        end
        R_DONE: begin
          for (int g = 0; g < 4; g++) begin
            read_data_out[16*g +: 8]     <= shadow_even[g];
            read_data_out[16*g + 8 +: 8] <= shadow_odd[g];
          end
          read_data_out[64 +: 8] <= shadow_even[4];
          read_valid_out         <= 1'b1;
          state                  <= IDLE;
        end
        RST: begin
          state   <= IDLE;
          instr_q <= IDLE_INSTRUCTION;
        end
        default: begin
          state   <= IDLE;
          instr_q <= IDLE_INSTRUCTION;
        end
      endcase
    end
  end

  always_ff @(negedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      neg_q       <= 1'b0;
      shadow_even <= '0;
    end else begin
      if (state == W_DATA) neg_q <= ~pos_q;
      if (state == R_DATA) shadow_even[grp] <= controller_data_in;
    end
  end

endmodule

// File: tb/tb_tensor_core_host_sequencer.sv
// tb/tb_tensor_core_host_sequencer.sv - randomized self-checking bench for tensor_core_host_sequencer
module tb_tensor_core_host_sequencer;
  localparam int WAIT_N = 6;

  logic         clock_in = 1'b0;
  logic         reset_in = 1'b0;
  logic         cmd_valid_in = 1'b0;
  logic         cmd_ready_out;
  logic [1:0]   cmd_op_in = '0;
  logic [2:0]   cmd_opselect_in = '0;
  logic [143:0] write_matrices_in = '0;
  logic [15:0]  instruction_out;
  logic [7:0]   controller_data_in = '0;
  logic [71:0]  read_data_out;
  logic         read_valid_out;
  logic         busy_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [71:0] exp_rd  = '0;

  tensor_core_host_sequencer #(.OPERATE_WAIT_CYCLES(WAIT_N), .IDLE_INSTRUCTION(16'h0000)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .cmd_valid_in(cmd_valid_in),
    .cmd_ready_out(cmd_ready_out), .cmd_op_in(cmd_op_in), .cmd_opselect_in(cmd_opselect_in),
    .write_matrices_in(write_matrices_in), .instruction_out(instruction_out),
    .controller_data_in(controller_data_in), .read_data_out(read_data_out),
    .read_valid_out(read_valid_out), .busy_out(busy_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [143:0] m, input int k);
    if (k >= 18) return 8'h00;
    return m[8*k +: 8];
  endfunction

  function automatic logic [15:0] header(input logic [1:0] op, input logic [2:0] sel);
    case (op)
      2'd0:    return 16'h0007;
      2'd1:    return 16'h0002 | (16'(sel) << 2);
      2'd2:    return 16'h0003;
      default: return 16'h000C;
    endcase
  endfunction

  function automatic int busy_len(input logic [1:0] op);
    case (op)
      2'd0:    return 6;
      2'd1:    return 1 + WAIT_N;
      2'd2:    return 7;
      default: return 1;
    endcase
  endfunction

  function automatic logic [143:0] rand144();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[32*i +: 32] = $urandom;
    return t[143:0];
  endfunction

  function automatic logic [71:0] rand72();
    logic [95:0] t;
    for (int i = 0; i < 3; i++) t[32*i +: 32] = $urandom;
    return t[71:0];
  endfunction

  // Issue one command and follow it cycle by cycle; abort_at >= 0 pulses reset in that cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [143:0] mat,
                         input logic [71:0] elems, input bit hold, input int abort_at);
    int          waited;
    int          len;
    int          g;
    bit          stop;
    logic [15:0] ehi, elo;
    cmd_op_in = op;
    cmd_opselect_in = sel;
    write_matrices_in = mat;
    cmd_valid_in = 1'b1;
    waited = 0;
    while (cmd_ready_out !== 1'b1 && waited < 50) begin
      @(posedge clock_in); #1;
      waited++;
    end
    check("ready_before_accept", 72'(cmd_ready_out), 72'(1));
    @(posedge clock_in); #1;
    if (!hold) cmd_valid_in = 1'b0;
    write_matrices_in = rand144();
    cmd_opselect_in = 3'($urandom);
    len = busy_len(op);
    stop = 1'b0;
    for (int c = 0; c <= len && !stop; c++) begin
      ehi = 16'h0000;
      elo = 16'h0000;
      if (c == 0) begin
        ehi = header(op, sel);
        elo = ehi;
      end else if (op == 2'd0 && c <= 5) begin
        g = c - 1;
        ehi = {mbyte(mat, 4*g), mbyte(mat, 4*g + 1)};
        elo = {mbyte(mat, 4*g + 2), mbyte(mat, 4*g + 3)};
      end
      check("instr_hi", 72'(instruction_out), 72'(ehi));
      check("ready", 72'(cmd_ready_out), 72'(c == len));
      check("busy", 72'(busy_out), 72'(c != len));
      check("rd_valid", 72'(read_valid_out), 72'(op == 2'd2 && c == len));
      if (op == 2'd2 && c == len) exp_rd = elems;
      check("rd_data", read_data_out, exp_rd);
      if (c == abort_at) begin
        cmd_valid_in = 1'b0;
        reset_in = 1'b0;
        #1;
        check("abort_instr", 72'(instruction_out), 72'(0));
        check("abort_ready", 72'(cmd_ready_out), 72'(1));
        check("abort_rd_data", read_data_out, 72'(0));
        exp_rd = '0;
        #1 reset_in = 1'b1;
        stop = 1'b1;
      end else if (c != len) begin
        if (op == 2'd2 && c >= 1 && c <= 5) controller_data_in = elems[16*(c-1) +: 8];
        else controller_data_in = 8'($urandom);
        @(negedge clock_in); #1;
        check("instr_lo", 72'(instruction_out), 72'(elo));
        if (op == 2'd2 && c >= 1 && c <= 4) controller_data_in = elems[16*(c-1) + 8 +: 8];
        else if (op == 2'd2 && c == 5) controller_data_in = elems[7:0];
        else controller_data_in = 8'($urandom);
        @(posedge clock_in); #1;
      end
    end
  endtask

  initial begin
    logic [143:0] m;
    logic [71:0]  e;
    #3;
    check("rst_instr", 72'(instruction_out), 72'(0));
    check("rst_ready", 72'(cmd_ready_out), 72'(1));
    check("rst_busy", 72'(busy_out), 72'(0));
    check("rst_rd_valid", 72'(read_valid_out), 72'(0));
    check("rst_rd_data", read_data_out, 72'(0));
    @(posedge clock_in); #2 reset_in = 1'b1;
    @(posedge clock_in); #1;

    for (int k = 0; k < 18; k++) m[8*k +: 8] = 8'(k + 1);
    run_cmd(2'd0, 3'd0, m, '0, 1'b0, -1);
    for (int k = 0; k < 9; k++) e[8*k +: 8] = 8'(8'h10 + k);
    run_cmd(2'd2, 3'd0, '0, e, 1'b0, -1);
    run_cmd(2'd1, 3'b101, '0, '0, 1'b1, -1);
    run_cmd(2'd3, 3'd0, '0, '0, 1'b1, -1);
    check("rd_data_after_rst_cmd", read_data_out, e);
    run_cmd(2'd0, 3'd0, rand144(), '0, 1'b0, 3);

    run_cmd(2'd0, 3'd0, rand144(), '0, 1'b1, -1);
    run_cmd(2'd1, 3'($urandom), '0, '0, 1'b1, -1);
    run_cmd(2'd2, 3'd0, '0, rand72(), 1'b1, -1);
    run_cmd(2'd3, 3'd0, '0, '0, 1'b1, -1);

    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom), rand144(), rand72(), 1'($urandom), -1);
      if ($urandom_range(0, 3) == 0) begin
        cmd_valid_in = 1'b0;
        for (int j = 0; j < 2; j++) begin
          @(posedge clock_in); #1;
          check("gap_instr", 72'(instruction_out), 72'(0));
          check("gap_ready", 72'(cmd_ready_out), 72'(1));
          check("gap_rd_valid", 72'(read_valid_out), 72'(0));
        end
      end
    end
    cmd_valid_in = 1'b0;
    @(posedge clock_in); #1;
    check("final_ready", 72'(cmd_ready_out), 72'(1));
    check("final_rd_data", read_data_out, exp_rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tensor_core_host_sequencer.md
Name: tensor_core_host_sequencer

Overview:
- Host-side driver for the tensor core controller's 16-bit instruction port and 8-bit result bus.
- Accepts high-level commands over a valid/ready handshake: burst-write two 3x3 int8 matrices, operate, burst-read the 3x3 result, or reset.
- Serialises each command into the exact double-data-rate instruction stream the controller consumes.
- Deserialises the controller's double-rate burst-read output back into a 9-byte result.

Parameters:
- OPERATE_WAIT_CYCLES, 6: NOP cycles issued after an operate instruction before the next command is accepted. Must be ≥ 6.
- IDLE_INSTRUCTION, 16'h0000: instruction driven when no command is active (generic NOP).

Ports:
- clock_in  input  1  single system clock; both edges are used for the data phases.
- reset_in  input  1  asynchronous active-low reset.
- cmd_valid_in  input  1  command request.
- cmd_ready_out  output  1  high only in IDLE.
- cmd_op_in  input  2  command code: 0 = burst write, 1 = operate, 2 = burst read, 3 = reset.
- cmd_opselect_in  input  3  matrix operation select for the operate command.
- write_matrices_in  input  144  byte k = [8k+7:8k]. k 0..8 is matrix 0 row-major; k 9..17 is matrix 1.
- instruction_out  output  16  instruction stream to the controller.
- controller_data_in  input  8  controller output bus, signed.
- read_data_out  output  72  element e = [8e+7:8e], row-major result.
- read_valid_out  output  1  one-cycle pulse when read_data_out has been updated.
- busy_out  output  1  equals ~cmd_ready_out.

Behaviour:
- Cycle convention: cycle n is posedge n to posedge n+1. "High phase" and "low phase" are the halves of a cycle before and after its negedge.
- Reset (reset_in = 0, async):
  - state = IDLE, instruction_out = IDLE_INSTRUCTION, read_data_out = 0, read_valid_out = 0, cmd_ready_out = 1.
  - Internal counters and snapshot registers are cleared.
  - Reset mid-burst aborts immediately. The controller is left to time out on its own.
- Acceptance: a command is accepted at a posedge when cmd_valid_in && cmd_ready_out.
  - cmd_op_in, cmd_opselect_in and write_matrices_in are snapshotted at that edge.
  - Later input changes have no effect on the accepted command.
- States: IDLE, W_HDR, W_DATA, OP_ISSUE, OP_WAIT, R_HDR, R_DATA, RST, R_DONE.
- Header encodings, driven for exactly one cycle (the cycle after acceptance):
  - Burst write: 16'h0007.
  - Burst read: 16'h0003.
  - Operate: {11'b0, opselect, 2'b10}.
  - Reset: 16'h000C.
- Burst write: W_HDR (1 cycle), then W_DATA for 5 cycles, groups g = 0..4.
  - High phase of group g: instruction_out = {byte 4g, byte 4g+1}.
  - Low phase of group g: instruction_out = {byte 4g+2, byte 4g+3}, updated at the negedge.
  - Bytes 18 and 19 are driven as 8'h00.
  - After group 4: instruction_out = IDLE_INSTRUCTION at the next posedge; return to IDLE. cmd_ready_out is high that same cycle.
  - Total busy = 6 cycles.
- Operate: OP_ISSUE (1 cycle), then OP_WAIT for OPERATE_WAIT_CYCLES cycles driving IDLE_INSTRUCTION, then IDLE.
- Burst read: R_HDR (1 cycle), then R_DATA for 5 cycles, groups g = 0..4, with instruction_out = IDLE_INSTRUCTION throughout.
  - At the negedge of group g, controller_data_in is captured as element 2g.
  - At the posedge ending group g, it is captured as element 2g+1, for g < 4.
  - At g = 4 the low-phase byte is the wrapped element 0 and is discarded.
  - Captures go into a shadow buffer. The R_DONE cycle copies the shadow to read_data_out and asserts read_valid_out for exactly 1 cycle, then returns to IDLE.
  - read_data_out holds its value until the next completed read.
- Reset command: RST drives 16'h000C for 1 cycle, then IDLE. read_data_out is not cleared.
- cmd_valid_in asserted while busy is ignored (no queueing); the requester holds it until ready.
- Illegal states recover to IDLE.
- Instruction changes occur only at posedges, except the W_DATA low-phase update at the negedge.

Test Plan:
1. Burst write with bytes k = k+1 → instruction_out sequence:
   - 0x0007
   - 0x0102 / 0x0304
   - 0x0506 / 0x0708
   - 0x090A / 0x0B0C
   - 0x0D0E / 0x0F10
   - 0x1112 / 0x0000
   - then 0x0000; cmd_ready_out returns high 6 cycles after acceptance.
2. Burst read with a controller model returning element e = 0x10+e, high phase then low phase → read_data_out bytes 0x10..0x18. read_valid_out pulses once, 7 cycles after acceptance. The wrap byte 0x10 in group 4's low phase is not written.
3. Operate, cmd_opselect_in = 3'b101 → one cycle of 0x0016, then 6 cycles of 0x0000. A command held valid during this period is accepted only on the 8th cycle.
4. Assert reset_in low in write group 2 → instruction_out = 0x0000 immediately (async), cmd_ready_out = 1, read_data_out = 0.
5. Change write_matrices_in after acceptance of a burst write → transmitted bytes equal the snapshot values.
6. Back-to-back: write, operate, read, reset, all with valid held high → headers 0x0007, 0x0002 | opselect<<2, 0x0003, 0x000C in order, with no overlap and no dropped command.
